// File: rtl/router_pkt_ingress.sv
// rtl/router_pkt_ingress.sv - 1x3 router ingress: header decode, FIFO write steering, back-pressure, parity check
module router_pkt_ingress (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] data_in,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [2:0] fifo_full,
  input  logic [2:0] soft_reset,
  output logic [7:0] dout,
  output logic [2:0] write_enb,
  output logic       lfd_state,
  output logic       busy,
  output logic       err,
  output logic       pkt_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_SPACE,
    S_LFD,
    S_WR_HDR,
    S_PAYLOAD,
    S_PARITY,
    S_DROP
  } state_t;

  state_t     state;
  logic [7:0] hdr_reg;
  logic [7:0] par;
  logic [5:0] cnt;

  logic [1:0] addr;
  logic       addr_ok;
  logic [2:0] addr_onehot;
  logic       sel_full;
  logic       sel_sreset;
  logic       sreset_hit;
  logic       fire;

  assign addr        = hdr_reg[1:0];
  assign addr_ok     = (addr != 2'd3);
  // Shifting past bit 2 truncates to zero, so address 3 never selects a FIFO.
  assign addr_onehot = 3'b001 << addr;
  assign fire        = in_valid && in_ready;
  assign lfd_state   = (state == S_LFD);
  assign busy        = (state != S_IDLE);

  // Select the full / soft-reset flag of the destination FIFO; address 3 has none.
  always_comb begin
    sel_full   = 1'b0;
    sel_sreset = 1'b0;
    case (addr)
      2'd0: begin sel_full = fifo_full[0]; sel_sreset = soft_reset[0]; end
      2'd1: begin sel_full = fifo_full[1]; sel_sreset = soft_reset[1]; end
      2'd2: begin sel_full = fifo_full[2]; sel_sreset = soft_reset[2]; end
      default: begin sel_full = 1'b0; sel_sreset = 1'b0; end
    endcase
  end

  // Soft reset only matters while the packet is bound to a real FIFO.
  always_comb begin
    sreset_hit = 1'b0;
    case (state)
      S_WAIT_SPACE, S_LFD, S_WR_HDR, S_PAYLOAD, S_PARITY: sreset_hit = sel_sreset;
      default: sreset_hit = 1'b0;
    endcase
  end

  // Handshake and FIFO write path; payload/parity pass straight through to the FIFO bus.
  always_comb begin
    in_ready  = 1'b0;
    dout      = 8'd0;
    write_enb = 3'b000;
    case (state)
      S_IDLE: in_ready = 1'b1;
      S_WR_HDR: begin
        dout = hdr_reg;
        if (!sreset_hit && addr_ok) write_enb = addr_onehot;
      end
      S_PAYLOAD, S_PARITY: begin
        // Holding off on soft reset keeps the flushing byte for DROP to count.
        in_ready = !sel_full && !sel_sreset;
        dout     = data_in;
        if (in_valid && !sel_full && !sel_sreset && addr_ok) write_enb = addr_onehot;
      end
      S_DROP: in_ready = 1'b1;
      default: begin
        in_ready  = 1'b0;
        dout      = 8'd0;
        write_enb = 3'b000;
      end
    endcase
  end

  // Packet sequencing FSM with parity accumulation and status flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      hdr_reg  <= 8'd0;
      par      <= 8'd0;
      cnt      <= 6'd0;
      err      <= 1'b0;
      pkt_done <= 1'b0;
    end else begin
      pkt_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (fire) begin
            hdr_reg <= data_in;
            par     <= data_in;
            cnt     <= data_in[7:2];
            if (data_in[1:0] == 2'd3) begin
              state <= S_DROP;
              err   <= 1'b1;
            end else begin
              state <= S_WAIT_SPACE;
              err   <= 1'b0;
            end
          end
        end
        S_WAIT_SPACE: begin
          if (sreset_hit) begin
            state <= S_DROP;
            err   <= 1'b1;
          end else if (!sel_full) begin
            state <= S_LFD;
          end
        end
        S_LFD: begin
          if (sreset_hit) begin
            state <= S_DROP;
            err   <= 1'b1;
          end else begin
            state <= S_WR_HDR;
          end
        end
        S_WR_HDR: begin
          if (sreset_hit) begin
            state <= S_DROP;
            err   <= 1'b1;
          end else begin
            state <= (cnt != 6'd0) ? S_PAYLOAD : S_PARITY;
          end
        end
        S_PAYLOAD: begin
          if (sreset_hit) begin
            state <= S_DROP;
            err   <= 1'b1;
          end else if (fire) begin
            par <= par ^ data_in;
            cnt <= cnt - 6'd1;
            if (cnt == 6'd1) state <= S_PARITY;
          end
        end
        S_PARITY: begin
          if (sreset_hit) begin
            state <= S_DROP;
            err   <= 1'b1;
          end else if (fire) begin
            err      <= (data_in != par);
            pkt_done <= 1'b1;
            state    <= S_IDLE;
          end
        end
        S_DROP: begin
          // cnt holds the payload bytes still owed; the parity byte follows cnt==0.
          if (fire) begin
            if (cnt == 6'd0) begin
              pkt_done <= 1'b1;
              state    <= S_IDLE;
            end else begin
              cnt <= cnt - 6'd1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
